// File: rtl/simplex_tableau_loader.sv
// Streams an LP problem (A, b, f) in and writes the full initial simplex tableau,
// one cell per cycle: coefficients, slack identity, negated objective and zero fill.
module simplex_tableau_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int NCOEFMAX   = 2,
    parameter int NREQMAX    = 1,
    parameter int NRLEQMAX   = 1
) (
    input  logic                                          clk_i,
    input  logic                                          rstn_i,
    input  logic                                          start_i,
    input  logic [$clog2(NCOEFMAX+1)-1:0]                 ncoef_i,
    input  logic [$clog2(NRLEQMAX+1)-1:0]                 nrleq_i,
    input  logic [$clog2(NREQMAX+1)-1:0]                  nreq_i,
    input  logic [DATA_WIDTH-1:0]                         s_data_i,
    input  logic                                          s_valid_i,
    output logic                                          s_ready_o,
    output logic                                          wr_en_o,
    output logic [$clog2(NREQMAX+NRLEQMAX+1)-1:0]         wr_row_o,
    output logic [$clog2(NCOEFMAX+NRLEQMAX+1)-1:0]        wr_col_o,
    output logic [DATA_WIDTH-1:0]                         wr_data_o,
    output logic                                          busy_o,
    output logic                                          done_o,
    output logic                                          err_o
);

    localparam int NROWS = NREQMAX + NRLEQMAX;
    localparam int NCOLS = NCOEFMAX + NRLEQMAX + 1;
    localparam int RW    = $clog2(NROWS + 1);
    localparam int CW    = $clog2(NCOLS);
    localparam logic [DATA_WIDTH-1:0] FP_ONE = DATA_WIDTH'(32'h3F80_0000);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [RW-1:0]                      r_row;
    logic [CW-1:0]                      r_col;
    logic [$clog2(NCOEFMAX+1)-1:0]      r_ncoef;
    logic [$clog2(NRLEQMAX+1)-1:0]      r_nrleq;
    logic [$clog2(NREQMAX+1)-1:0]       r_nreq;
    logic                               r_wr_en;
    logic [RW-1:0]                      r_wr_row;
    logic [CW-1:0]                      r_wr_col;
    logic [DATA_WIDTH-1:0]              r_wr_data;
    logic                               r_done;
    logic                               r_err;

    logic [31:0]            w_r;
    logic [31:0]            w_c;
    logic [31:0]            w_nc;
    logic [31:0]            w_nl;
    logic [31:0]            w_ne;
    logic [31:0]            w_eqk;
    logic [31:0]            w_slk;
    logic                   w_legal;
    logic                   w_start_ok;
    logic                   w_is_obj;
    logic                   w_leq_act;
    logic                   w_eq_act;
    logic                   w_con_act;
    logic                   w_is_rhs;
    logic                   w_is_slack;
    logic                   w_src;
    logic                   w_last;
    logic                   w_handled;
    logic [DATA_WIDTH-1:0]  w_cell;

    // Cell classification, all done in 32-bit space to keep compares width-clean.
    assign w_r   = 32'(r_row);
    assign w_c   = 32'(r_col);
    assign w_nc  = 32'(r_ncoef);
    assign w_nl  = 32'(r_nrleq);
    assign w_ne  = 32'(r_nreq);
    assign w_eqk = w_r - 32'(NRLEQMAX);
    assign w_slk = w_c - 32'(NCOEFMAX);

    assign w_legal    = (32'(ncoef_i) <= 32'(NCOEFMAX)) &&
                        (32'(nrleq_i) <= 32'(NRLEQMAX)) &&
                        (32'(nreq_i)  <= 32'(NREQMAX));
    assign w_start_ok = (r_state == S_IDLE) && start_i && !r_done;

    assign w_is_obj   = (w_r == 32'(NROWS));
    assign w_leq_act  = (w_r < 32'(NRLEQMAX)) && (w_r < w_nl);
    assign w_eq_act   = (w_r >= 32'(NRLEQMAX)) && !w_is_obj && (w_eqk < w_ne);
    assign w_con_act  = w_leq_act || w_eq_act;
    assign w_is_rhs   = (w_c == 32'(NCOLS - 1));
    assign w_is_slack = (w_c >= 32'(NCOEFMAX)) && !w_is_rhs;
    assign w_src      = (w_con_act && ((w_c < w_nc) || w_is_rhs)) ||
                        (w_is_obj && (w_c < w_nc));
    assign w_last     = w_is_obj && w_is_rhs;

    // State register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start_ok && w_legal) w_next = S_LOAD;
            S_LOAD:  if (w_handled && w_last)   w_next = S_FLUSH;
            S_FLUSH: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output / cell-data logic
    always_comb begin
        s_ready_o = 1'b0;
        w_handled = 1'b0;
        w_cell    = '0;
        if (r_state == S_LOAD) begin
            s_ready_o = w_src;
            w_handled = w_src ? s_valid_i : 1'b1;
        end
        if (w_src) begin
            w_cell = s_data_i;
            // Maximisation objective enters the tableau as -f: flip the sign bit only.
            if (w_is_obj) w_cell[DATA_WIDTH-1] = ~s_data_i[DATA_WIDTH-1];
        end else if (w_is_slack && w_leq_act && (w_r == w_slk)) begin
            w_cell = FP_ONE;
        end
    end

    // Pointer, latched configuration and registered write port
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_row     <= '0;
            r_col     <= '0;
            r_ncoef   <= '0;
            r_nrleq   <= '0;
            r_nreq    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_row  <= '0;
            r_wr_col  <= '0;
            r_wr_data <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_wr_en <= w_handled;
            r_done  <= (r_state == S_FLUSH);
            r_err   <= w_start_ok && !w_legal;
            if (w_handled) begin
                r_wr_row  <= r_row;
                r_wr_col  <= r_col;
                r_wr_data <= w_cell;
            end
            if (w_start_ok && w_legal) begin
                r_ncoef <= ncoef_i;
                r_nrleq <= nrleq_i;
                r_nreq  <= nreq_i;
                r_row   <= '0;
                r_col   <= '0;
            end else if (w_handled) begin
                if (w_is_rhs) begin
                    r_col <= '0;
                    r_row <= w_last ? '0 : r_row + RW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end
        end
    end

    assign wr_en_o   = r_wr_en;
    assign wr_row_o  = r_wr_row;
    assign wr_col_o  = r_wr_col;
    assign wr_data_o = r_wr_data;
    assign done_o    = r_done;
    assign err_o     = r_err;
    assign busy_o    = (r_state != S_IDLE) || r_done;

endmodule

// File: tb/tb_simplex_tableau_loader.sv
// Bench for simplex_tableau_loader: table-driven loads with a write scoreboard,
// plus hand-written error, mid-load reset and restart sequences.
module tb_simplex_tableau_loader;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [1:0]  ncoef;
    logic        nrleq;
    logic        nreq;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        wr_en;
    logic [1:0]  wr_row;
    logic [1:0]  wr_col;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    simplex_tableau_loader #(
        .DATA_WIDTH(32),
        .NCOEFMAX  (2),
        .NREQMAX   (1),
        .NRLEQMAX  (1)
    ) dut (
        .clk_i    (clk),
        .rstn_i   (rstn),
        .start_i  (start),
        .ncoef_i  (ncoef),
        .nrleq_i  (nrleq),
        .nreq_i   (nreq),
        .s_data_i (s_data),
        .s_valid_i(s_valid),
        .s_ready_o(s_ready),
        .wr_en_o  (wr_en),
        .wr_row_o (wr_row),
        .wr_col_o (wr_col),
        .wr_data_o(wr_data),
        .busy_o   (busy),
        .done_o   (done),
        .err_o    (err)
    );

    typedef struct {
        logic [1:0]  row;
        logic [1:0]  col;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [1:0]  nc;
        logic        nl;
        logic        ne;
        int          nw;
        logic [31:0] w[8];
        logic [31:0] e[12];
        bit          stall;
        bit          midstart;
        int          done_cyc;
    } vec_t;

    wr_t  exp_q[$];
    vec_t vecs[4];
    int   total   = 0;
    int   bad     = 0;
    int   wr_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Scoreboard: every observed write pops the next expected cell.
    always @(negedge clk) begin : mon
        wr_t e;
        if (rstn === 1'b1 && wr_en === 1'b1) begin
            wr_seen++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write actual=r%0d c%0d %h required=no write",
                         wr_row, wr_col, wr_data);
            end else begin
                e = exp_q.pop_front();
                chk("write", {28'd0, wr_row, wr_col, wr_data}, {28'd0, e.row, e.col, e.data});
            end
        end
    end

    task automatic run_load(input vec_t v, input int abort_after, output bit aborted);
        int  idx;
        int  k;
        int  base;
        bit  seen;
        bit  consume;
        bit  busy_ok;
        wr_t t;
        for (int i = 0; i < 12; i++) begin
            t.row  = 2'(i / 4);
            t.col  = 2'(i % 4);
            t.data = v.e[i];
            exp_q.push_back(t);
        end
        base = wr_seen; idx = 0; k = 1; seen = 0; busy_ok = 1; aborted = 0;
        @(posedge clk); #1;
        ncoef = v.nc; nrleq = v.nl; nreq = v.ne; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (!seen && k < 200) begin
            s_valid = (idx < v.nw) && !(v.stall && (k % 2 == 0));
            s_data  = (idx < v.nw) ? v.w[idx] : 32'h0;
            start   = v.midstart && (k == 5);
            @(negedge clk); #1;
            consume = s_valid && s_ready;
            if (busy !== 1'b1) busy_ok = 0;
            if (done === 1'b1) seen = 1;
            if (abort_after > 0 && (wr_seen - base) >= abort_after) begin
                aborted = 1;
                break;
            end
            @(posedge clk); #1;
            if (consume) idx++;
            if (!seen) k++;
        end
        start   = 1'b0;
        s_valid = 1'b0;
        if (!aborted) begin
            chk("done_cycle", 64'(k), 64'(v.done_cyc));
            chk("busy_during_load", 64'(busy_ok), 64'd1);
            chk("words_consumed", 64'(idx), 64'(v.nw));
            chk("all_writes_seen", 64'(exp_q.size()), 64'd0);
            @(negedge clk);
            chk("idle_after_done", {62'd0, busy, done}, 64'd0);
        end
    endtask

    initial begin
        bit ab;

        vecs[0].nc = 2; vecs[0].nl = 1; vecs[0].ne = 1; vecs[0].nw = 8;
        vecs[0].w  = '{32'h3F800000, 32'h40000000, 32'h41000000, 32'h40400000,
                       32'h40000000, 32'h41400000, 32'h40400000, 32'h40A00000};
        vecs[0].e  = '{32'h3F800000, 32'h40000000, 32'h3F800000, 32'h41000000,
                       32'h40400000, 32'h40000000, 32'h00000000, 32'h41400000,
                       32'hC0400000, 32'hC0A00000, 32'h00000000, 32'h00000000};
        vecs[0].stall = 0; vecs[0].midstart = 0; vecs[0].done_cyc = 14;

        vecs[1] = vecs[0];
        vecs[1].stall = 1; vecs[1].done_cyc = 19;

        vecs[2].nc = 1; vecs[2].nl = 1; vecs[2].ne = 0; vecs[2].nw = 3;
        vecs[2].w  = '{32'h40000000, 32'h40800000, 32'h3F800000, 32'h0,
                       32'h0, 32'h0, 32'h0, 32'h0};
        vecs[2].e  = '{32'h40000000, 32'h00000000, 32'h3F800000, 32'h40800000,
                       32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
                       32'hBF800000, 32'h00000000, 32'h00000000, 32'h00000000};
        vecs[2].stall = 0; vecs[2].midstart = 0; vecs[2].done_cyc = 14;

        vecs[3] = vecs[0];
        vecs[3].midstart = 1;

        rstn = 1'b0; start = 1'b0; ncoef = '0; nrleq = '0; nreq = '0;
        s_valid = 1'b1; s_data = 32'hDEADBEEF;
        #12;
        chk("reset_outputs", {s_ready, wr_en, busy, done, err, wr_row, wr_col, wr_data}, 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("idle_no_ready", {61'd0, s_ready, busy, wr_en}, 64'd0);
        s_valid = 1'b0;

        for (int i = 0; i < 4; i++) begin
            run_load(vecs[i], 0, ab);
        end

        // Illegal configuration: ncoef above the maximum.
        @(posedge clk); #1;
        ncoef = 2'd3; nrleq = 1'b1; nreq = 1'b1; start = 1'b1;
        s_valid = 1'b1; s_data = 32'h3F800000;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("err_pulse", {60'd0, err, busy, s_ready, wr_en}, 64'b1000);
        @(negedge clk);
        chk("err_one_cycle", {60'd0, err, busy, s_ready, wr_en}, 64'd0);
        s_valid = 1'b0;

        // Reset after five writes, then a full reload from (0,0).
        run_load(vecs[0], 5, ab);
        chk("abort_reached", 64'(ab), 64'd1);
        rstn = 1'b0;
        #1;
        chk("midload_reset_outputs",
            {s_ready, wr_en, busy, done, err, wr_row, wr_col, wr_data}, 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_held_outputs", {59'd0, s_ready, wr_en, busy, done, err}, 64'd0);
        rstn = 1'b1;
        run_load(vecs[0], 0, ab);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
